// File: rtl/clock_div_ctrl.sv
// Programmable clock divider with runt-free ratio changes.
// The ratio is taken over valid/ready and applied only at period wrap.
module clock_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             div_valid_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             div_ready_o,
  output logic             div_err_o,
  output logic             clk_en_o,
  output logic             clk_o,
  output logic [CNT_W-1:0] counter_o,
  output logic             locked_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             err_q, err_d;
  logic             xfer, legal, wrap;

  assign div_ready_o = (state_q != PEND);
  assign xfer        = div_valid_i & div_ready_o;
  assign legal       = (div_i > ONE);
  assign wrap        = (cnt_q == (cur_q - ONE));

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    err_d   = xfer & ~legal;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (xfer && legal) cur_d = div_i;
        if (enable_i) state_d = RUN;
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (xfer && legal) cur_d = div_i;
        end else begin
          cnt_d = wrap ? '0 : cnt_q + ONE;
          if (xfer && legal) begin
            pend_d  = div_i;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          cur_d   = pend_q;
        end else if (wrap) begin
          state_d = RUN;
          cnt_d   = '0;
          cur_d   = pend_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // registered clock derived from next-state so it lines up with counter_o
    clk_d = (state_d != IDLE) && (cnt_d >= (cur_d >> 1));
  end

  always_ff @(posedge clk_i) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= DEF;
      pend_q  <= '0;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      err_q   <= err_d;
    end
  end

  assign clk_en_o  = (state_q != IDLE) && wrap;
  assign clk_o     = clk_q;
  assign counter_o = cnt_q;
  assign div_err_o = err_q;
  assign locked_o  = (state_q == RUN);

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl: vector table plus
// hand-written sequences for odd, large and idle-loaded ratios.
module tb_clock_div_ctrl;

  logic       clk_i = 1'b0;
  logic       reset;
  logic       enable_i;
  logic       div_valid_i;
  logic [7:0] div_i;
  logic       div_ready_o;
  logic       div_err_o;
  logic       clk_en_o;
  logic       clk_o;
  logic [7:0] counter_o;
  logic       locked_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  clock_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .enable_i    (enable_i),
    .div_valid_i (div_valid_i),
    .div_i       (div_i),
    .div_ready_o (div_ready_o),
    .div_err_o   (div_err_o),
    .clk_en_o    (clk_en_o),
    .clk_o       (clk_o),
    .counter_o   (counter_o),
    .locked_o    (locked_o)
  );

  typedef struct {
    logic       r, e, v;
    logic [7:0] d;
    logic       rdy, err, cen, clk;
    logic [7:0] cnt;
    logic       lck;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, logic v, logic [7:0] d,
                              logic rdy, logic err, logic cen, logic clk,
                              logic [7:0] cnt, logic lck);
    vec_t x;
    x.r = r; x.e = e; x.v = v; x.d = d;
    x.rdy = rdy; x.err = err; x.cen = cen; x.clk = clk;
    x.cnt = cnt; x.lck = lck;
    return x;
  endfunction

  task automatic chk(string nm, int idx, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, got, exp);
    end
  endtask

  task automatic step(logic r, logic e, logic v, logic [7:0] d);
    reset = r; enable_i = e; div_valid_i = v; div_i = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all(string tag, int idx, logic rdy, logic err,
                         logic cen, logic clk, logic [7:0] cnt, logic lck);
    chk({tag, ".ready"}, idx, 8'(div_ready_o), 8'(rdy));
    chk({tag, ".err"}, idx, 8'(div_err_o), 8'(err));
    chk({tag, ".clk_en"}, idx, 8'(clk_en_o), 8'(cen));
    chk({tag, ".clk"}, idx, 8'(clk_o), 8'(clk));
    chk({tag, ".cnt"}, idx, counter_o, cnt);
    chk({tag, ".locked"}, idx, 8'(locked_o), 8'(lck));
  endtask

  initial begin
    reset = 1'b0; enable_i = 1'b0; div_valid_i = 1'b0; div_i = '0;

    // reset for 2 cycles, offering 9 which must be ignored
    tbl.push_back(mk(0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,9, 1,0,0,0,0,0));
    // run at default ratio 4
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,1,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,1,2,1));
    tbl.push_back(mk(1,1,0,0, 1,0,1,1,3,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,1,1));
    // offer 6 at counter 1, applied at wrap
    tbl.push_back(mk(1,1,1,6, 0,0,0,1,2,0));
    tbl.push_back(mk(1,1,0,0, 0,0,1,1,3,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,1,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,2,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,1,3,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,1,4,1));
    tbl.push_back(mk(1,1,0,0, 1,0,1,1,5,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1));
    // back to 4, requested at counter 0
    tbl.push_back(mk(1,1,1,4, 0,0,0,0,1,0));
    tbl.push_back(mk(1,1,0,0, 0,0,0,0,2,0));
    tbl.push_back(mk(1,1,0,0, 0,0,0,1,3,0));
    tbl.push_back(mk(1,1,0,0, 0,0,0,1,4,0));
    tbl.push_back(mk(1,1,0,0, 0,0,1,1,5,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1));
    // illegal ratios 1 and 0
    tbl.push_back(mk(1,1,1,1, 1,1,0,0,1,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,1,2,1));
    tbl.push_back(mk(1,1,1,0, 1,1,1,1,3,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1));
    // pend 7 then drop enable: committed on the way to idle
    tbl.push_back(mk(1,1,1,7, 0,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,1,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,2,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,1,3,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,1,4,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,1,5,1));
    tbl.push_back(mk(1,1,0,0, 1,0,1,1,6,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1));
    // pend 5, reset at counter 2 with 9 offered
    tbl.push_back(mk(1,1,1,5, 0,0,0,0,1,0));
    tbl.push_back(mk(1,1,0,0, 0,0,0,0,2,0));
    tbl.push_back(mk(0,1,1,9, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,9, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,1,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,1,2,1));
    tbl.push_back(mk(1,1,0,0, 1,0,1,1,3,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d);
      chk_all("tbl", i, tbl[i].rdy, tbl[i].err, tbl[i].cen,
              tbl[i].clk, tbl[i].cnt, tbl[i].lck);
    end

    // ratio 5 loaded in idle together with enable rise
    step(1, 0, 0, 0);
    chk("r5.idle_lck", 0, 8'(locked_o), 8'd0);
    step(1, 1, 1, 5);
    chk_all("r5.start", 0, 1, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, 0, 0);
      chk_all("r5", i, 1, 0, (i % 5) == 4, (i % 5) >= 2, 8'(i % 5), 1);
    end

    // ratio 255: wrap at 254, high from 127
    step(1, 0, 0, 0);
    step(1, 1, 1, 255);
    chk("r255.cnt", 0, counter_o, 8'd0);
    for (int i = 1; i <= 300; i++) begin
      step(1, 1, 0, 0);
      chk("r255.cnt", i, counter_o, 8'(i % 255));
      chk("r255.clk", i, 8'(clk_o), 8'((i % 255) >= 127));
      chk("r255.cen", i, 8'(clk_en_o), 8'((i % 255) == 254));
    end

    // ratio 3 loaded while idle, then enabled later
    step(1, 0, 0, 0);
    step(1, 0, 1, 3);
    chk_all("r3.idle", 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0);
    chk_all("r3.start", 0, 1, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      step(1, 1, 0, 0);
      chk_all("r3", i, 1, 0, (i % 3) == 2, (i % 3) >= 1, 8'(i % 3), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
